hazard_scheduler: RTL and testbench

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

---
 rtl/hazard_scheduler.sv | 139 +++++++++++++
 tb/tb_hazard_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// hazard_scheduler
// ----------------
// Single-issue hazard scheduler that sits between fetch and execute. It
// decodes the fetched instruction, looks up a per-register write-back
// scoreboard and either issues the instruction, issues a bubble, or holds
// fetch until the operands are safe and execute is ready.
//
// Ports:
//   clk          clock, all state updates on posedge
//   reset        synchronous, active-high reset
//   instr        20-bit instruction from fetch
//   fetch_valid  instr is meaningful this cycle
//   ex_ready     execute stage accepts an issue this cycle
//   hold         combinational, freezes the fetch PC
//   issue_instr  registered instruction to execute (20'h0 = bubble)
//   issue_valid  registered, issue_instr is a real operation
//   busy         combinational, any scoreboard counter nonzero
//   stall_cnt    registered saturating count of hold cycles
//   issue_cnt    registered count of issued operations, wraps at 256
//   illegal      registered sticky undefined-opcode flag
module hazard_scheduler #(
    parameter int WB_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] instr,
    input  logic        fetch_valid,
    input  logic        ex_ready,
    output logic        hold,
    output logic [19:0] issue_instr,
    output logic        issue_valid,
    output logic        busy,
    output logic [7:0]  stall_cnt,
    output logic [7:0]  issue_cnt,
    output logic        illegal
);

    localparam logic [2:0] LAT = 3'(WB_LAT);

    logic [3:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic        isIType;
    logic        isRType;
    logic        isNot;
    logic        isReal;
    logic        isIllegal;
    logic        hazard;
    logic        doIssue;
    logic        consume;

    logic [2:0]  cnt_q [4];
    logic [2:0]  cnt_d [4];
    logic [19:0] issueInstr_q, issueInstr_d;
    logic        issueValid_q, issueValid_d;
    logic [7:0]  stallCnt_q, stallCnt_d;
    logic [7:0]  issueCnt_q, issueCnt_d;
    logic        illegal_q, illegal_d;

    // Field decode and opcode classification. Opcode 0000 is a null no
    // matter what the remaining bits hold, so only the op nibble matters.
    always_comb begin
        op        = instr[19:16];
        rd        = instr[9:8];
        rs        = instr[1:0];
        isIType   = (op == 4'b0011) || (op == 4'b0101);
        isRType   = (op == 4'b0010) || (op == 4'b0100) || (op == 4'b1010) ||
                    (op == 4'b1100) || (op == 4'b1110);
        isNot     = (op == 4'b1000);
        isReal    = isIType || isRType || isNot;
        isIllegal = !isReal && (op != 4'b0000);
    end

    // Only real operations can raise a hazard; I-type and not read rd
    // only, R-type also reads rs.
    always_comb begin
        hazard  = isReal && ((cnt_q[rd] != 3'd0) ||
                             (isRType && (cnt_q[rs] != 3'd0)));
        hold    = fetch_valid && (hazard || !ex_ready);
        doIssue = fetch_valid && ex_ready && isReal && !hazard;
        consume = fetch_valid && ex_ready && !isReal;
        busy    = (cnt_q[0] != 3'd0) || (cnt_q[1] != 3'd0) ||
                  (cnt_q[2] != 3'd0) || (cnt_q[3] != 3'd0);
    end

    // Scoreboard next state: the issued rd reloads with the write-back
    // latency, every other nonzero counter counts down each cycle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (doIssue && (rd == 2'(i))) begin
                cnt_d[i] = LAT;
            end else if (cnt_q[i] != 3'd0) begin
                cnt_d[i] = cnt_q[i] - 3'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Issue register, counters and sticky illegal flag.
    always_comb begin
        issueInstr_d = doIssue ? instr : 20'h0;
        issueValid_d = doIssue;
        issueCnt_d   = doIssue ? issueCnt_q + 8'd1 : issueCnt_q;
        stallCnt_d   = (hold && (stallCnt_q != 8'hFF)) ? stallCnt_q + 8'd1
                                                        : stallCnt_q;
        illegal_d    = illegal_q || (consume && isIllegal);
    end

    // State registers; reset wins over any concurrent issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 3'd0;
            end
            issueInstr_q <= 20'h0;
            issueValid_q <= 1'b0;
            stallCnt_q   <= 8'd0;
            issueCnt_q   <= 8'd0;
            illegal_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            issueInstr_q <= issueInstr_d;
            issueValid_q <= issueValid_d;
            stallCnt_q   <= stallCnt_d;
            issueCnt_q   <= issueCnt_d;
            illegal_q    <= illegal_d;
        end
    end

    assign issue_instr = issueInstr_q;
    assign issue_valid = issueValid_q;
    assign stall_cnt   = stallCnt_q;
    assign issue_cnt   = issueCnt_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler
// -------------------
// Directed bench for hazard_scheduler with WB_LAT = 3. A table of
// per-cycle vectors holds the inputs, the expected combinational hold
// before the edge and the expected registered outputs after the edge.
// Hand-written loops cover stall-count saturation and issue-count wrap.
module tb_hazard_scheduler;

    logic        clk;
    logic        reset;
    logic [19:0] instr;
    logic        fetch_valid;
    logic        ex_ready;
    logic        hold;
    logic [19:0] issue_instr;
    logic        issue_valid;
    logic        busy;
    logic [7:0]  stall_cnt;
    logic [7:0]  issue_cnt;
    logic        illegal;

    int compared;
    int mismatched;

    typedef struct {
        logic        rst;
        logic [19:0] ins;
        logic        fv;
        logic        er;
        logic        expHold;
        logic        expValid;
        logic [19:0] expInstr;
        logic        expBusy;
        logic [7:0]  expStall;
        logic [7:0]  expIssue;
        logic        expIllegal;
    } vec_t;

    localparam int NVEC = 36;
    vec_t vecs [NVEC];

    hazard_scheduler #(.WB_LAT(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .fetch_valid (fetch_valid),
        .ex_ready    (ex_ready),
        .hold        (hold),
        .issue_instr (issue_instr),
        .issue_valid (issue_valid),
        .busy        (busy),
        .stall_cnt   (stall_cnt),
        .issue_cnt   (issue_cnt),
        .illegal     (illegal)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s step %0d: got 0x%0h, expected 0x%0h",
                     name, idx, actual, expected);
        end
    endtask

    // Drive inputs away from the active edge; leave time for hold to settle.
    task automatic applyStimulus(input logic r, input logic [19:0] i,
                                 input logic fv, input logic er);
        @(negedge clk);
        reset       = r;
        instr       = i;
        fetch_valid = fv;
        ex_ready    = er;
        #1;
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        reset       = 1'b1;
        instr       = 20'h0;
        fetch_valid = 1'b0;
        ex_ready    = 1'b1;

        //                rst  instr     fv  er  hold val issueInstr busy stall issue ill
        vecs[0]  = '{1'b1, 20'h00000, 0, 1, 0, 0, 20'h00000, 0, 8'd0, 8'd0, 0};
        // addi R1 then dependent add R1,R3: three hold cycles
        vecs[1]  = '{1'b0, 20'h3008F, 1, 1, 0, 1, 20'h3008F, 1, 8'd0, 8'd1, 0};
        vecs[2]  = '{1'b0, 20'h20002, 1, 1, 1, 0, 20'h00000, 1, 8'd1, 8'd1, 0};
        vecs[3]  = '{1'b0, 20'h20002, 1, 1, 1, 0, 20'h00000, 1, 8'd2, 8'd1, 0};
        vecs[4]  = '{1'b0, 20'h20002, 1, 1, 1, 0, 20'h00000, 0, 8'd3, 8'd1, 0};
        vecs[5]  = '{1'b0, 20'h20002, 1, 1, 0, 1, 20'h20002, 1, 8'd3, 8'd2, 0};
        vecs[6]  = '{1'b0, 20'h00000, 0, 1, 0, 0, 20'h00000, 1, 8'd3, 8'd2, 0};
        vecs[7]  = '{1'b0, 20'h00000, 0, 1, 0, 0, 20'h00000, 1, 8'd3, 8'd2, 0};
        vecs[8]  = '{1'b0, 20'h00000, 0, 1, 0, 0, 20'h00000, 0, 8'd3, 8'd2, 0};
        // independent addi R3 / addi R2 back to back
        vecs[9]  = '{1'b0, 20'h3021B, 1, 1, 0, 1, 20'h3021B, 1, 8'd3, 8'd3, 0};
        vecs[10] = '{1'b0, 20'h301FA, 1, 1, 0, 1, 20'h301FA, 1, 8'd3, 8'd4, 0};
        vecs[11] = '{1'b0, 20'h00000, 0, 1, 0, 0, 20'h00000, 1, 8'd3, 8'd4, 0};
        vecs[12] = '{1'b0, 20'h00000, 0, 1, 0, 0, 20'h00000, 1, 8'd3, 8'd4, 0};
        vecs[13] = '{1'b0, 20'h00000, 0, 1, 0, 0, 20'h00000, 0, 8'd3, 8'd4, 0};
        // not R4 with execute not ready for five cycles
        vecs[14] = '{1'b0, 20'h80300, 1, 0, 1, 0, 20'h00000, 0, 8'd4, 8'd4, 0};
        vecs[15] = '{1'b0, 20'h80300, 1, 0, 1, 0, 20'h00000, 0, 8'd5, 8'd4, 0};
        vecs[16] = '{1'b0, 20'h80300, 1, 0, 1, 0, 20'h00000, 0, 8'd6, 8'd4, 0};
        vecs[17] = '{1'b0, 20'h80300, 1, 0, 1, 0, 20'h00000, 0, 8'd7, 8'd4, 0};
        vecs[18] = '{1'b0, 20'h80300, 1, 0, 1, 0, 20'h00000, 0, 8'd8, 8'd4, 0};
        vecs[19] = '{1'b0, 20'h80300, 1, 1, 0, 1, 20'h80300, 1, 8'd8, 8'd5, 0};
        vecs[20] = '{1'b0, 20'h00000, 0, 1, 0, 0, 20'h00000, 1, 8'd8, 8'd5, 0};
        vecs[21] = '{1'b0, 20'h00000, 0, 1, 0, 0, 20'h00000, 1, 8'd8, 8'd5, 0};
        vecs[22] = '{1'b0, 20'h00000, 0, 1, 0, 0, 20'h00000, 0, 8'd8, 8'd5, 0};
        // null then illegal op: bubbles, illegal becomes sticky
        vecs[23] = '{1'b0, 20'h0FF7E, 1, 1, 0, 0, 20'h00000, 0, 8'd8, 8'd5, 0};
        vecs[24] = '{1'b0, 20'h70000, 1, 1, 0, 0, 20'h00000, 0, 8'd8, 8'd5, 1};
        vecs[25] = '{1'b0, 20'h00000, 0, 1, 0, 0, 20'h00000, 0, 8'd8, 8'd5, 1};
        // no hold without fetch_valid even when execute is not ready
        vecs[26] = '{1'b0, 20'h3008F, 0, 0, 0, 0, 20'h00000, 0, 8'd8, 8'd5, 1};
        // hazard stall interrupted by reset
        vecs[27] = '{1'b0, 20'h3008F, 1, 1, 0, 1, 20'h3008F, 1, 8'd8, 8'd6, 1};
        vecs[28] = '{1'b0, 20'h20002, 1, 1, 1, 0, 20'h00000, 1, 8'd9, 8'd6, 1};
        vecs[29] = '{1'b1, 20'h20002, 1, 1, 1, 0, 20'h00000, 0, 8'd0, 8'd0, 0};
        vecs[30] = '{1'b0, 20'h20002, 1, 1, 0, 1, 20'h20002, 1, 8'd0, 8'd1, 0};
        // R-type hazard through rs only (xor R2,R1 while R1 pending)
        vecs[31] = '{1'b0, 20'h00000, 0, 1, 0, 0, 20'h00000, 1, 8'd0, 8'd1, 0};
        vecs[32] = '{1'b0, 20'hA0100, 1, 1, 1, 0, 20'h00000, 1, 8'd1, 8'd1, 0};
        vecs[33] = '{1'b0, 20'hA0100, 1, 1, 1, 0, 20'h00000, 0, 8'd2, 8'd1, 0};
        vecs[34] = '{1'b0, 20'hA0100, 1, 1, 0, 1, 20'hA0100, 1, 8'd2, 8'd2, 0};
        // I-type ignores the rs field even when that register is pending
        vecs[35] = '{1'b0, 20'h30201, 1, 1, 0, 1, 20'h30201, 1, 8'd2, 8'd3, 0};

        for (int v = 0; v < NVEC; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].ins, vecs[v].fv, vecs[v].er);
            checkOutput("hold", v, 32'(hold), 32'(vecs[v].expHold));
            waitEdge();
            checkOutput("issue_valid", v, 32'(issue_valid), 32'(vecs[v].expValid));
            checkOutput("issue_instr", v, 32'(issue_instr), 32'(vecs[v].expInstr));
            checkOutput("busy",        v, 32'(busy),        32'(vecs[v].expBusy));
            checkOutput("stall_cnt",   v, 32'(stall_cnt),   32'(vecs[v].expStall));
            checkOutput("issue_cnt",   v, 32'(issue_cnt),   32'(vecs[v].expIssue));
            checkOutput("illegal",     v, 32'(illegal),     32'(vecs[v].expIllegal));
        end

        // 300 hold cycles with execute not ready: stall count saturates.
        for (int c = 0; c < 300; c++) begin
            applyStimulus(1'b0, 20'h00000, 1'b1, 1'b0);
            waitEdge();
        end
        checkOutput("stall_sat", 300, 32'(stall_cnt), 32'd255);
        checkOutput("stall_sat_valid", 300, 32'(issue_valid), 32'd0);
        applyStimulus(1'b0, 20'h00000, 1'b1, 1'b0);
        waitEdge();
        checkOutput("stall_hold255", 301, 32'(stall_cnt), 32'd255);

        // Reset, then 257 addi ops rotating rd so none ever hazards.
        applyStimulus(1'b1, 20'h00000, 1'b0, 1'b1);
        waitEdge();
        checkOutput("reset_stall", 0, 32'(stall_cnt), 32'd0);
        checkOutput("reset_issue", 0, 32'(issue_cnt), 32'd0);
        for (int n = 0; n < 257; n++) begin
            logic [19:0] op;
            op = {4'h3, 6'h0, 2'(n % 4), 8'(n)};
            applyStimulus(1'b0, op, 1'b1, 1'b1);
            checkOutput("wrap_hold", n, 32'(hold), 32'd0);
            waitEdge();
            if (n == 255) begin
                checkOutput("wrap_256", n, 32'(issue_cnt), 32'd0);
            end
        end
        checkOutput("wrap_257", 257, 32'(issue_cnt), 32'd1);
        checkOutput("wrap_stall", 257, 32'(stall_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
